pipe_hazard_ctrl: RTL and testbench

- Central stall/flush/debug-halt sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards between ID and EX, and issues a PC stall plus a bubble.
- Squashes younger instructions when a branch or jump resolves in MEM.
- Provides a debug halt/single-step FSM and saturating stall/flush event counters. Drives the write enables and flushes of the PC and pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush/debug-halt sequencer for a 5-stage RISC-V pipeline
//               with saturating load-use stall and redirect event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_jump,
  input  logic             dbg_halt_req,
  input  logic             dbg_step,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_en,
  output logic             redirect,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0]       c_ST_RUN  = 2'd0;
  localparam logic [1:0]       c_ST_HALT = 2'd1;
  localparam logic [1:0]       c_ST_STEP = 2'd2;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_lu;
  logic             w_rd;
  logic             w_active;

  assign w_lu = id_valid & ex_memRead & (ex_rd != 5'd0) &
                ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  assign w_rd = mem_branch_taken | mem_jump;

  // The control outputs are forced inactive while reset is held low.
  assign w_active = rst & (r_state != c_ST_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_RUN: begin
        if (dbg_halt_req) w_next_state = c_ST_HALT;
      end
      c_ST_HALT: begin
        if (dbg_step)           w_next_state = c_ST_STEP;
        else if (!dbg_halt_req) w_next_state = c_ST_RUN;
      end
      c_ST_STEP: begin
        w_next_state = dbg_halt_req ? c_ST_HALT : c_ST_RUN;
      end
      default: w_next_state = c_ST_RUN;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_en     = 1'b0;
    redirect    = 1'b0;
    halted      = (r_state == c_ST_HALT);
    if (w_active) begin
      pipe_en = 1'b1;
      if (w_rd) begin
        redirect    = 1'b1;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (w_lu) begin
        idex_flush  = 1'b1;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (w_active) begin
      if (w_rd) begin
        if (r_flush_count != c_CNT_MAX) r_flush_count <= r_flush_count + c_CNT_ONE;
      end else if (w_lu) begin
        if (r_stall_count != c_CNT_MAX) r_stall_count <= r_stall_count + c_CNT_ONE;
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed table-driven bench for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs2, ex_memRead, mem_branch_taken, mem_jump;
  logic        dbg_halt_req, dbg_step;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic        pipe_en, redirect, halted;
  logic [15:0] stall_count, flush_count;
  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_flush;
  logic        s_pipe_en, s_redirect, s_halted;
  logic [1:0]  s_stall_count, s_flush_count;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_memRead(ex_memRead), .ex_rd(ex_rd),
    .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump),
    .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pipe_en(pipe_en),
    .redirect(redirect), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_memRead(ex_memRead), .ex_rd(ex_rd),
    .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump),
    .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .pipe_en(s_pipe_en),
    .redirect(s_redirect), .halted(s_halted),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_en, redirect, halted}
  localparam logic [7:0] NORM  = 8'b1100_0100;
  localparam logic [7:0] STALL = 8'b0001_0100;
  localparam logic [7:0] RDIR  = 8'b1111_1110;
  localparam logic [7:0] HLT   = 8'b0000_0001;
  localparam logic [7:0] OFF   = 8'b0000_0000;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use2;
    logic        mrd;
    logic [4:0]  exrd;
    logic        br;
    logic        jmp;
    logic        hreq;
    logic        step;
    logic [7:0]  exp;
    logic [15:0] esc;
    logic [15:0] efc;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic use2, input logic mrd, input logic [4:0] exrd,
                              input logic br, input logic jmp, input logic hreq, input logic step,
                              input logic [7:0] exp, input logic [15:0] esc, input logic [15:0] efc);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.use2 = use2; v.mrd = mrd; v.exrd = exrd;
    v.br = br; v.jmp = jmp; v.hreq = hreq; v.step = step;
    v.exp = exp; v.esc = esc; v.efc = efc;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_en, redirect, halted};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.use2;
    ex_memRead = v.mrd; ex_rd = v.exrd; mem_branch_taken = v.br; mem_jump = v.jmp;
    dbg_halt_req = v.hreq; dbg_step = v.step;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 0, 0));
  endtask

  initial begin
    // Counter columns hold the value expected before that vector's clock edge.
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0, 0);
    tbl[1]  = mk(1, 5, 0, 0, 1, 5, 0, 0, 0, 0, STALL, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  1, 0);
    tbl[3]  = mk(1, 1, 5, 0, 1, 5, 0, 0, 0, 0, NORM,  1, 0);
    tbl[4]  = mk(1, 1, 5, 1, 1, 5, 0, 0, 0, 0, STALL, 1, 0);
    tbl[5]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, NORM,  2, 0);
    tbl[6]  = mk(0, 5, 0, 0, 1, 5, 0, 0, 0, 0, NORM,  2, 0);
    tbl[7]  = mk(1, 5, 0, 0, 1, 5, 1, 0, 0, 0, RDIR,  2, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RDIR,  2, 1);
    tbl[9]  = mk(1, 5, 0, 0, 0, 5, 0, 0, 0, 0, NORM,  2, 2);
    tbl[10] = mk(1, 5, 0, 0, 1, 5, 0, 0, 1, 0, STALL, 2, 2);
    tbl[11] = mk(1, 5, 0, 0, 1, 5, 1, 0, 1, 0, HLT,   3, 2);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, HLT,   3, 2);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, RDIR,  3, 2);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HLT,   3, 3);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, HLT,   3, 3);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM,  3, 3);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  3, 3);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM,  3, 3);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NORM,  3, 3);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, HLT,   3, 3);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  3, 3);

    // Reset held with a redirect pending: everything inactive.
    rst = 1'b0;
    idle();
    mem_branch_taken = 1'b1;
    #3;
    chk("reset_outs", {8'h00, outs()}, {8'h00, OFF});
    @(negedge clk);
    chk("reset_outs_edge", {8'h00, outs()}, {8'h00, OFF});
    chk("reset_stall_cnt", stall_count, 16'd0);
    chk("reset_flush_cnt", flush_count, 16'd0);
    #1 rst = 1'b1;
    mem_branch_taken = 1'b0;
    #1;
    chk("post_reset_outs", {8'h00, outs()}, {8'h00, NORM});

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d_outs", i), {8'h00, outs()}, {8'h00, tbl[i].exp});
      chk($sformatf("vec%0d_stall_cnt", i), stall_count, tbl[i].esc);
      chk($sformatf("vec%0d_flush_cnt", i), flush_count, tbl[i].efc);
    end

    // Asynchronous reset while halted.
    @(negedge clk);
    idle();
    dbg_halt_req = 1'b1;
    @(negedge clk);
    #1;
    chk("halt_before_rst", {8'h00, outs()}, {8'h00, HLT});
    #1 rst = 1'b0;
    #1;
    chk("rst_in_halt_outs", {8'h00, outs()}, {8'h00, OFF});
    chk("rst_in_halt_stall", stall_count, 16'd0);
    chk("rst_in_halt_flush", flush_count, 16'd0);
    dbg_halt_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("run_after_rst", {8'h00, outs()}, {8'h00, NORM});
    @(negedge clk);
    #1;
    chk("run_after_rst_edge", {8'h00, outs()}, {8'h00, NORM});

    // Five back-to-back stalls; the 2-bit instance must saturate at 3.
    @(negedge clk);
    drive(mk(1, 7, 0, 0, 1, 7, 0, 0, 0, 0, OFF, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat_stall%0d", i), {14'd0, s_stall_count}, (i < 3) ? 16'(i + 1) : 16'd3);
      chk($sformatf("wide_stall%0d", i), stall_count, 16'(i + 1));
    end
    @(negedge clk);
    idle();
    mem_jump = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat_flush%0d", i), {14'd0, s_flush_count}, (i < 3) ? 16'(i + 1) : 16'd3);
    end
    chk("sat_stall_hold", {14'd0, s_stall_count}, 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
